// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default line timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int UART_CLOCKS_PER_PULSE = 5208;
    localparam int UART_BITS_PER_WORD    = 8;

endpackage

// File: rtl/uart_word_tx_if.sv
// Producer-side valid/ready handshake carrying one multi-word payload.
interface uart_word_tx_if #(
    parameter int NUM_WORDS     = 2,
    parameter int BITS_PER_WORD = 8
) ();

    logic                                     s_valid;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  s_data;
    logic                                     s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-runs while enabled and pulses tick on the last clock of each UART bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_PULSE - 1);

    logic [CNT_W-1:0] clk_cnt_r;

    // Count clocks within the current bit; parked at zero while disabled so each frame starts aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_r <= '0;
        end else if (!en) begin
            clk_cnt_r <= '0;
        end else if (clk_cnt_r == LAST) begin
            clk_cnt_r <= '0;
        end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
        end
    end

    assign tick = en && (clk_cnt_r == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Serialises one W_OUT-bit payload as NUM_WORDS back-to-back UART frames (start, LSB-first data, stop).
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = UART_BITS_PER_WORD,
    parameter int W_OUT            = 16,
    parameter int STOP_BITS        = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_word_tx_if.slave s_if,
    output logic          tx,
    output logic          busy
);

    localparam int NUM_WORDS  = W_OUT / BITS_PER_WORD;
    localparam int BIT_CNT_W  = $clog2(BITS_PER_WORD + 1);
    localparam int WORD_IDX_W = $clog2(NUM_WORDS + 1);

    localparam logic [BIT_CNT_W-1:0]  LAST_DATA_BIT = BIT_CNT_W'(BITS_PER_WORD);
    localparam logic [BIT_CNT_W-1:0]  LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD     = WORD_IDX_W'(NUM_WORDS - 1);

    tx_state_e               state_r,    state_s;
    logic [W_OUT-1:0]        shift_r,    shift_s;
    logic [BIT_CNT_W-1:0]    bit_cnt_r,  bit_cnt_s;
    logic [WORD_IDX_W-1:0]   word_idx_r, word_idx_s;
    logic                    tx_r,       tx_s;
    logic                    busy_r,     busy_s;
    logic                    tick_s;
    logic                    ready_s;
    logic                    accept_s;

    assign ready_s     = (state_r == IDLE) && !rst;
    assign accept_s    = s_if.s_valid && ready_s;
    assign s_if.s_ready = ready_s;
    assign tx          = tx_r;
    assign busy        = busy_r;

    uart_bit_timer #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state_r != IDLE),
        .tick (tick_s)
    );

    // Next-state and next-line-level logic; tx_s is the level the line takes after the coming edge.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        word_idx_s = word_idx_r;
        tx_s       = tx_r;
        busy_s     = busy_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s    = START;
                    shift_s    = s_if.s_data;
                    bit_cnt_s  = '0;
                    word_idx_s = '0;
                    tx_s       = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    tx_s   = 1'b1;
                    busy_s = 1'b0;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s   = DATA;
                    tx_s      = shift_r[0];
                    shift_s   = {1'b0, shift_r[W_OUT-1:1]};
                    bit_cnt_s = BIT_CNT_W'(1);
                end else begin
                    tx_s = 1'b0;
                end
            end
            DATA: begin
                if (!tick_s) begin
                    state_s = DATA;
                end else if (bit_cnt_r == LAST_DATA_BIT) begin
                    state_s   = STOP;
                    tx_s      = 1'b1;
                    bit_cnt_s = '0;
                end else begin
                    tx_s      = shift_r[0];
                    shift_s   = {1'b0, shift_r[W_OUT-1:1]};
                    bit_cnt_s = bit_cnt_r + BIT_CNT_W'(1);
                end
            end
            STOP: begin
                // bit_cnt is reused here to count stop bits.
                if (!tick_s) begin
                    tx_s = 1'b1;
                end else if (bit_cnt_r != LAST_STOP_BIT) begin
                    bit_cnt_s = bit_cnt_r + BIT_CNT_W'(1);
                end else if (word_idx_r < LAST_WORD) begin
                    state_s    = START;
                    tx_s       = 1'b0;
                    bit_cnt_s  = '0;
                    word_idx_s = word_idx_r + WORD_IDX_W'(1);
                end else begin
                    state_s    = IDLE;
                    tx_s       = 1'b1;
                    busy_s     = 1'b0;
                    bit_cnt_s  = '0;
                    word_idx_s = '0;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_s       = 1'b1;
                busy_s     = 1'b0;
                bit_cnt_s  = '0;
                word_idx_s = '0;
            end
        endcase
    end

    // State, payload and line registers; reset abandons any frame with the line idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            word_idx_r <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            word_idx_r <= word_idx_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: line levels are predicted cycle-by-cycle from the frame format.
module tb_uart_word_tx;

    localparam int CPP = 4;
    localparam int BPW = 8;
    localparam int W   = 16;
    localparam int NW  = W / BPW;

    logic clk = 1'b0;
    logic rst;
    logic tx, busy, tx2, busy2;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_word_tx_if #(.NUM_WORDS(NW), .BITS_PER_WORD(BPW)) bus  ();
    uart_word_tx_if #(.NUM_WORDS(NW), .BITS_PER_WORD(BPW)) bus2 ();

    uart_word_tx #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .W_OUT(W), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .s_if(bus), .tx(tx), .busy(busy)
    );

    uart_word_tx #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .W_OUT(W), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .rst(rst), .s_if(bus2), .tx(tx2), .busy(busy2)
    );

    // Line level k cycles after acceptance (k=0 is the first cycle of the start bit).
    function automatic logic expected_line(input logic [15:0] payload, input int stop_bits, input int k);
        int frame_len;
        int bit_pos;
        int w;
        int p;
        frame_len = 1 + BPW + stop_bits;
        bit_pos   = k / CPP;
        w         = bit_pos / frame_len;
        p         = bit_pos % frame_len;
        if (p == 0)        return 1'b0;
        else if (p <= BPW) return payload[w*BPW + p - 1];
        else               return 1'b1;
    endfunction

    task automatic start_tx(input logic [15:0] payload, input bit use2, input bit hold);
        logic rdy;
        @(negedge clk);
        if (use2) begin bus2.s_valid = 1'b1; bus2.s_data = payload; end
        else      begin bus.s_valid  = 1'b1; bus.s_data  = payload; end
        #1;
        rdy = use2 ? bus2.s_ready : bus.s_ready;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_accept: s_ready=%b expected 1", rdy);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.s_valid  = 1'b0;
            bus2.s_valid = 1'b0;
        end
    endtask

    // Follows a whole transaction from the cycle after acceptance, then checks the idle cycle after it.
    task automatic check_frame(input logic [15:0] payload, input int stop_bits, input string name, input int change_at);
        int   total;
        logic lt, lb, lr, et;
        total = NW * (1 + BPW + stop_bits) * CPP;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k == change_at) begin
                bus.s_data  = '0;
                bus2.s_data = '0;
            end
            lt = (stop_bits == 2) ? tx2 : tx;
            lb = (stop_bits == 2) ? busy2 : busy;
            et = expected_line(payload, stop_bits, k);
            n_checks++;
            if (lt !== et || lb !== 1'b1) begin
                n_fail++;
                $display("FAIL %s cycle %0d: tx=%b busy=%b expected tx=%b busy=1", name, k, lt, lb, et);
            end
        end
        @(negedge clk);
        lt = (stop_bits == 2) ? tx2 : tx;
        lb = (stop_bits == 2) ? busy2 : busy;
        lr = (stop_bits == 2) ? bus2.s_ready : bus.s_ready;
        n_checks++;
        if (lt !== 1'b1 || lb !== 1'b0 || lr !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_end: tx=%b busy=%b s_ready=%b expected 1 0 1", name, lt, lb, lr);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.s_valid  = 1'b1;
        bus.s_data   = 16'($urandom);
        bus2.s_valid = 1'b1;
        bus2.s_data  = 16'($urandom);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0 ||
                tx2 !== 1'b1 || busy2 !== 1'b0 || bus2.s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: tx=%b busy=%b s_ready=%b tx2=%b busy2=%b s_ready2=%b expected 1 0 0 1 0 0",
                         tx, busy, bus.s_ready, tx2, busy2, bus2.s_ready);
            end
        end
        rst          = 1'b0;
        bus.s_valid  = 1'b0;
        bus2.s_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus2.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: s_ready=%b s_ready2=%b expected 1 1", bus.s_ready, bus2.s_ready);
        end
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_start: tx=%b busy=%b tx2=%b busy2=%b expected 1 0 1 0", tx, busy, tx2, busy2);
            end
        end
    endtask

    task automatic test_single();
        start_tx(16'hA53C, 1'b0, 1'b0);
        check_frame(16'hA53C, 1, "single", -1);
    endtask

    task automatic test_random();
        logic [15:0] p;
        repeat (4) begin
            p = 16'($urandom);
            start_tx(p, 1'b0, 1'b0);
            check_frame(p, 1, "random", -1);
        end
    endtask

    task automatic test_back_to_back();
        start_tx(16'h1234, 1'b0, 1'b1);
        check_frame(16'h1234, 1, "b2b_first", -1);
        bus.s_data = 16'hFFFF;
        check_frame(16'hFFFF, 1, "b2b_second", -1);
        bus.s_valid = 1'b0;
    endtask

    task automatic test_stability();
        start_tx(16'h5A5A, 1'b0, 1'b0);
        check_frame(16'h5A5A, 1, "stable", 2);
    endtask

    task automatic test_reset_mid();
        start_tx(16'hC3C3, 1'b0, 1'b0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== expected_line(16'hC3C3, 1, k)) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: tx=%b expected %b", k, tx, expected_line(16'hC3C3, 1, k));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tx=%b busy=%b s_ready=%b expected 1 0 0", tx, busy, bus.s_ready);
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle: tx=%b busy=%b expected 1 0", tx, busy);
            end
        end
        start_tx(16'h00FF, 1'b0, 1'b0);
        check_frame(16'h00FF, 1, "after_reset", -1);
    endtask

    task automatic test_stop2();
        logic [15:0] p;
        start_tx(16'hA53C, 1'b1, 1'b0);
        check_frame(16'hA53C, 2, "stop2", -1);
        p = 16'($urandom);
        start_tx(p, 1'b1, 1'b0);
        check_frame(p, 2, "stop2_random", -1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus2.s_valid = 1'b0;
        bus2.s_data  = '0;
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_stability();
        test_reset_mid();
        test_stop2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
